// File: rtl/eth_rx_pkg.sv
// Shared definitions for the GMII receive word packer.
//   PREAMBLE_BYTE / SFD_BYTE : GMII framing bytes.
//   rx_state_e               : receive framing state machine encoding.
//   rx_status_t / RX_STATUS_W: per-word status bundle in default-build widths
//                              (DATA_W=32, MAX_FRAME_BYTES=1518). RX_STATUS_W
//                              sizes the status_i input of data_status_pipeline.
package eth_rx_pkg;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam int unsigned DEF_DATA_W          = 32;
  localparam int unsigned DEF_BYTES           = DEF_DATA_W / 8;
  localparam int unsigned DEF_MAX_FRAME_BYTES = 1518;
  localparam int unsigned DEF_LEN_W           = $clog2(DEF_MAX_FRAME_BYTES + 1);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    PREAMBLE,
    PAYLOAD
  } rx_state_e;

  typedef struct packed {
    logic                 sof;
    logic                 eof;
    logic                 err;
    logic [DEF_BYTES-1:0] keep;
    logic [DEF_LEN_W-1:0] frame_len;
  } rx_status_t;

  localparam int unsigned RX_STATUS_W = $bits(rx_status_t);

endpackage

// File: rtl/gmii_rx_word_packer_if.sv
// Packed-word output bus of gmii_rx_word_packer.
//   data_o      : packed word, lane 0 [7:0] is the earliest byte
//   valid_o     : word and status valid this cycle
//   sof_o/eof_o : first / last word of a frame
//   err_o       : frame error (meaningful with eof_o)
//   keep_o      : per-lane byte valid
//   frame_len_o : payload byte count (meaningful with eof_o)
// master: packer side (drives). slave: downstream consumer.
interface gmii_rx_word_packer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 11
) ();
  localparam int unsigned BYTES = DATA_W / 8;

  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              sof_o;
  logic              eof_o;
  logic              err_o;
  logic [BYTES-1:0]  keep_o;
  logic [LEN_W-1:0]  frame_len_o;

  modport master (
    output data_o, valid_o, sof_o, eof_o, err_o, keep_o, frame_len_o
  );

  modport slave (
    input data_o, valid_o, sof_o, eof_o, err_o, keep_o, frame_len_o
  );
endinterface

// File: rtl/gmii_rx_word_packer_byte_lane_packer.sv
// byte_lane_packer: little-endian byte-to-word assembly.
//   clk, rst : clock, synchronous active-high reset
//   clear_i  : drop the held word and restart at lane 0 (has priority)
//   push_i   : byte_i goes into the next lane; if the held word is full it is
//              replaced by a fresh word holding byte_i in lane 0
//   word_o   : held word, unfilled lanes are zero
//   fill_o   : number of filled lanes (0..BYTES); BYTES means a complete word
//              is being held until the owner decides whether it is the last
module byte_lane_packer #(
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned BYTES  = DATA_W / 8,
  localparam int unsigned FILL_W = $clog2(BYTES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic [FILL_W-1:0] fill_o
);

  logic [DATA_W-1:0] word_q, word_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  always_comb begin
    word_d = word_q;
    fill_d = fill_q;
    if (clear_i) begin
      word_d = '0;
      fill_d = '0;
    end else if (push_i) begin
      if (fill_q == FILL_W'(BYTES)) begin
        word_d      = '0;
        word_d[7:0] = byte_i;
        fill_d      = FILL_W'(1);
      end else begin
        for (int unsigned i = 0; i < BYTES; i++) begin
          if (fill_q == FILL_W'(i)) word_d[i*8 +: 8] = byte_i;
        end
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      fill_q <= '0;
    end else begin
      word_q <= word_d;
      fill_q <= fill_d;
    end
  end

  assign word_o = word_q;
  assign fill_o = fill_q;

endmodule

// File: rtl/gmii_rx_word_packer.sv
// gmii_rx_word_packer: strips GMII preamble/SFD and packs payload bytes
// little-endian into DATA_W-bit words with per-word frame status.
//   clk, rst        : 125 MHz GMII clock, synchronous active-high reset
//   gmii_rxd_i      : GMII receive byte
//   gmii_rx_dv_i    : GMII data valid
//   gmii_rx_er_i    : GMII receive error
//   out_if (master) : data_o/valid_o/sof_o/eof_o/err_o/keep_o/frame_len_o
// Optional build macro GMII_PACKER_PREAMBLE_CHECK_EN: require exactly seven
// 0x55 bytes before the SFD; any other preamble silently drops the frame.
module gmii_rx_word_packer
  import eth_rx_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MIN_FRAME_BYTES = 64,
  parameter int unsigned MAX_FRAME_BYTES = 1518
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   gmii_rxd_i,
  input  logic                         gmii_rx_dv_i,
  input  logic                         gmii_rx_er_i,
  gmii_rx_word_packer_if.master        out_if
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned LEN_W  = $clog2(MAX_FRAME_BYTES + 1);
  localparam int unsigned FILL_W = $clog2(BYTES + 1);

  // GMII inputs are registered first; the FSM works on the registered copy,
  // which places the last/not-last decision one edge after the byte arrives
  // and the word output one edge after that.
  logic [7:0]        rxd_q, rxd_d;
  logic              dv_q, dv_d;
  logic              er_q, er_d;

  rx_state_e         state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              frame_err_q, frame_err_d;
  logic              sof_pend_q, sof_pend_d;
`ifdef GMII_PACKER_PREAMBLE_CHECK_EN
  logic [2:0]        pre_cnt_q, pre_cnt_d;
`endif

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;
  logic              out_err_q, out_err_d;
  logic [BYTES-1:0]  keep_q, keep_d;
  logic [LEN_W-1:0]  len_q, len_d;

  logic              pk_clear, pk_push;
  logic [DATA_W-1:0] pk_word;
  logic [FILL_W-1:0] pk_fill;
  logic [BYTES-1:0]  keep_mask;
  logic              start, emit, emit_eof, emit_err;
  logic [LEN_W-1:0]  emit_len;

  byte_lane_packer #(.DATA_W(DATA_W)) u_lanes (
    .clk     (clk),
    .rst     (rst),
    .clear_i (pk_clear),
    .push_i  (pk_push),
    .byte_i  (rxd_q),
    .word_o  (pk_word),
    .fill_o  (pk_fill)
  );

  always_comb begin
    keep_mask = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      keep_mask[i] = (FILL_W'(i) < pk_fill);
    end
  end

  always_comb begin
    rxd_d       = gmii_rxd_i;
    dv_d        = gmii_rx_dv_i;
    er_d        = gmii_rx_er_i;
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_err_d = frame_err_q;
    sof_pend_d  = sof_pend_q;
`ifdef GMII_PACKER_PREAMBLE_CHECK_EN
    pre_cnt_d   = pre_cnt_q;
`endif
    start    = 1'b0;
    pk_clear = 1'b0;
    pk_push  = 1'b0;
    emit     = 1'b0;
    emit_eof = 1'b0;
    emit_err = 1'b0;
    emit_len = '0;

    case (state_q)
      WAIT_IDLE: if (!dv_q) state_d = IDLE;

      IDLE: if (dv_q) begin
        if (rxd_q == PREAMBLE_BYTE) begin
          state_d = PREAMBLE;
`ifdef GMII_PACKER_PREAMBLE_CHECK_EN
          pre_cnt_d = 3'd1;
`endif
        end else if (rxd_q == SFD_BYTE) begin
`ifdef GMII_PACKER_PREAMBLE_CHECK_EN
          state_d = WAIT_IDLE;
`else
          start = 1'b1;
`endif
        end else begin
          state_d = WAIT_IDLE;
        end
      end

      PREAMBLE: begin
        if (!dv_q) begin
          state_d = IDLE;
        end else if (rxd_q == PREAMBLE_BYTE) begin
`ifdef GMII_PACKER_PREAMBLE_CHECK_EN
          if (pre_cnt_q == 3'd7) state_d = WAIT_IDLE;
          else                   pre_cnt_d = pre_cnt_q + 3'd1;
`endif
        end else if (rxd_q == SFD_BYTE) begin
`ifdef GMII_PACKER_PREAMBLE_CHECK_EN
          if (pre_cnt_q == 3'd7) start = 1'b1;
          else                   state_d = WAIT_IDLE;
`else
          start = 1'b1;
`endif
        end else begin
          state_d = WAIT_IDLE;
        end
      end

      PAYLOAD: begin
        if (!dv_q) begin
          // End of frame: flush whatever is held; an empty frame emits nothing.
          state_d  = IDLE;
          pk_clear = 1'b1;
          emit     = (pk_fill != '0);
          emit_eof = 1'b1;
          emit_err = frame_err_q | (cnt_q < LEN_W'(MIN_FRAME_BYTES));
          emit_len = cnt_q;
        end else if (cnt_q == LEN_W'(MAX_FRAME_BYTES)) begin
          // Byte MAX+1: discard it and close the frame as oversize.
          state_d  = WAIT_IDLE;
          pk_clear = 1'b1;
          emit     = (pk_fill != '0);
          emit_eof = 1'b1;
          emit_err = 1'b1;
          emit_len = cnt_q;
        end else begin
          // Another byte proves the held full word is not the last one.
          pk_push = 1'b1;
          cnt_d   = cnt_q + LEN_W'(1);
          if (er_q) frame_err_d = 1'b1;
          emit    = (pk_fill == FILL_W'(BYTES));
        end
      end

      default: state_d = WAIT_IDLE;
    endcase

    if (start) begin
      state_d     = PAYLOAD;
      cnt_d       = '0;
      frame_err_d = 1'b0;
      sof_pend_d  = 1'b1;
      pk_clear    = 1'b1;
    end

    valid_d   = 1'b0;
    data_d    = '0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    out_err_d = 1'b0;
    keep_d    = '0;
    len_d     = '0;
    if (emit) begin
      valid_d    = 1'b1;
      data_d     = pk_word;
      sof_d      = sof_pend_q;
      eof_d      = emit_eof;
      out_err_d  = emit_err;
      keep_d     = emit_eof ? keep_mask : '1;
      len_d      = emit_len;
      sof_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_q       <= '0;
      dv_q        <= 1'b0;
      er_q        <= 1'b0;
      state_q     <= WAIT_IDLE;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
      sof_pend_q  <= 1'b0;
`ifdef GMII_PACKER_PREAMBLE_CHECK_EN
      pre_cnt_q   <= '0;
`endif
      data_q      <= '0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      out_err_q   <= 1'b0;
      keep_q      <= '0;
      len_q       <= '0;
    end else begin
      rxd_q       <= rxd_d;
      dv_q        <= dv_d;
      er_q        <= er_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
      sof_pend_q  <= sof_pend_d;
`ifdef GMII_PACKER_PREAMBLE_CHECK_EN
      pre_cnt_q   <= pre_cnt_d;
`endif
      data_q      <= data_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      out_err_q   <= out_err_d;
      keep_q      <= keep_d;
      len_q       <= len_d;
    end
  end

  assign out_if.data_o      = data_q;
  assign out_if.valid_o     = valid_q;
  assign out_if.sof_o       = sof_q;
  assign out_if.eof_o       = eof_q;
  assign out_if.err_o       = out_err_q;
  assign out_if.keep_o      = keep_q;
  assign out_if.frame_len_o = len_q;

endmodule

// File: tb/tb_gmii_rx_word_packer.sv
module tb_gmii_rx_word_packer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTES  = 4;
  localparam int unsigned MIN_B  = 64;
  localparam int unsigned MAX_B  = 1518;
  localparam int unsigned LEN_W  = 11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rxd = '0;
  logic       dv  = 1'b0;
  logic       er  = 1'b0;

  gmii_rx_word_packer_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  gmii_rx_word_packer #(
    .DATA_W          (DATA_W),
    .MIN_FRAME_BYTES (MIN_B),
    .MAX_FRAME_BYTES (MAX_B)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .gmii_rxd_i   (rxd),
    .gmii_rx_dv_i (dv),
    .gmii_rx_er_i (er),
    .out_if       (bus)
  );

  always #4 clk = ~clk;

  typedef struct packed {
    logic [31:0]       edge_n;
    logic [DATA_W-1:0] data;
    logic              sof;
    logic              eof;
    logic              err;
    logic [BYTES-1:0]  keep;
    logic [LEN_W-1:0]  len;
  } obs_t;

  obs_t        act_q[$];
  obs_t        exp_q[$];
  obs_t        mon_o;
  int unsigned edge_n     = 0;
  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  // Capture every valid word, tagged with the index of the edge that produced it.
  always @(posedge clk) begin
    #1;
    edge_n++;
    if (bus.valid_o === 1'b1) begin
      mon_o.edge_n = edge_n;
      mon_o.data   = bus.data_o;
      mon_o.sof    = bus.sof_o;
      mon_o.eof    = bus.eof_o;
      mon_o.err    = bus.err_o;
      mon_o.keep   = bus.keep_o;
      mon_o.len    = bus.frame_len_o;
      for (int l = 0; l < BYTES; l++) if (mon_o.keep[l] !== 1'b1) mon_o.data[l*8 +: 8] = 8'h00;
      act_q.push_back(mon_o);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic drive(input logic [7:0] b, input logic v, input logic e);
    @(negedge clk);
    rxd = b;
    dv  = v;
    er  = e;
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
  endtask

  // Drives one frame and appends the words a correct packer must emit.
  // Model: payload bytes beyond MAX_B are dropped; words are consecutive
  // BYTES-sized chunks; each word appears two edges after its final byte
  // is sampled.
  task automatic send_frame(input int len, input int pre_n, input int er_idx,
                            input bit seq, input int gap, output int unsigned last_edge);
    logic [7:0]  pay[$];
    int unsigned edges[$];
    bit          any_er;
    bit          ok;
    int          n;
    int          last;
    logic [7:0]  b;
    obs_t        x;
    for (int i = 0; i < pre_n; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    any_er    = 1'b0;
    last_edge = 0;
    for (int i = 0; i < len; i++) begin
      b = seq ? 8'(i) : 8'($urandom);
      drive(b, 1'b1, (i == er_idx));
      pay.push_back(b);
      edges.push_back(edge_n + 1);
      if (i == er_idx && i < MAX_B) any_er = 1'b1;
    end
    for (int i = 0; i < gap; i++) drive(8'h00, 1'b0, 1'b0);
`ifdef GMII_PACKER_PREAMBLE_CHECK_EN
    ok = (pre_n == 7);
`else
    ok = 1'b1;
`endif
    n = (len > MAX_B) ? MAX_B : len;
    if (n > 0) last_edge = edges[n-1];
    if (ok && n > 0) begin
      for (int w = 0; w * BYTES < n; w++) begin
        x    = '0;
        last = ((w + 1) * BYTES < n) ? ((w + 1) * BYTES - 1) : (n - 1);
        for (int k = w * BYTES; k <= last; k++) begin
          x.data[(k - w * BYTES) * 8 +: 8] = pay[k];
          x.keep[k - w * BYTES] = 1'b1;
        end
        x.edge_n = edges[last] + 2;
        x.sof    = (w == 0);
        x.eof    = (last == n - 1);
        if (x.eof) begin
          x.err = any_er || (len > MAX_B) || (n < MIN_B);
          x.len = LEN_W'(n);
        end
        exp_q.push_back(x);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    compared++;
    if ({bus.valid_o, bus.sof_o, bus.eof_o, bus.err_o, bus.keep_o, bus.frame_len_o, bus.data_o} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: valid=%b data=%h keep=%h len=%0d, required all zero",
               bus.valid_o, bus.data_o, bus.keep_o, bus.frame_len_o);
    end
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if ({bus.valid_o, bus.sof_o, bus.eof_o, bus.err_o, bus.keep_o, bus.frame_len_o, bus.data_o} !== '0) begin
      mismatched++;
      $display("FAIL reset_after: valid=%b data=%h, required all zero", bus.valid_o, bus.data_o);
    end
    repeat (3) @(negedge clk);
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_min_frame();
    int unsigned le;
    send_frame(64, 7, -1, 1'b1, 1, le);
    drain();
    compared++;
    if (act_q.size() !== exp_q.size()) begin
      mismatched++;
      $display("FAIL min_count: got %0d words, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      compared++;
      if (act_q[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL min_word%0d: got e=%0d d=%h s=%b e=%b er=%b k=%h l=%0d, expected e=%0d d=%h s=%b e=%b er=%b k=%h l=%0d",
                 i, act_q[i].edge_n, act_q[i].data, act_q[i].sof, act_q[i].eof, act_q[i].err, act_q[i].keep, act_q[i].len,
                 exp_q[i].edge_n, exp_q[i].data, exp_q[i].sof, exp_q[i].eof, exp_q[i].err, exp_q[i].keep, exp_q[i].len);
      end
    end
    compared++;
    if (act_q.size() != 16 || act_q[0].data !== 32'h03020100 || act_q[0].sof !== 1'b1) begin
      mismatched++;
      $display("FAIL min_first: size=%0d data=%h sof=%b, required 16 words, 03020100, sof=1",
               act_q.size(), act_q[0].data, act_q[0].sof);
    end
    compared++;
    if (act_q.size() != 16 || act_q[15].data !== 32'h3F3E3D3C || act_q[15].eof !== 1'b1 ||
        act_q[15].keep !== 4'hF || act_q[15].err !== 1'b0 || act_q[15].len !== 11'd64 ||
        act_q[15].edge_n !== le + 2) begin
      mismatched++;
      $display("FAIL min_last: data=%h eof=%b keep=%h err=%b len=%0d edge=%0d, required 3f3e3d3c 1 f 0 64 edge=%0d",
               act_q[15].data, act_q[15].eof, act_q[15].keep, act_q[15].err, act_q[15].len, act_q[15].edge_n, le + 2);
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_partial_and_runt();
    int unsigned le;
    send_frame(66, 7, -1, 1'b0, 2, le);
    drain();
    compared++;
    if (act_q.size() != 17 || act_q[16].keep !== 4'h3 || act_q[16].len !== 11'd66 ||
        act_q[16].eof !== 1'b1 || act_q[16].err !== 1'b0) begin
      mismatched++;
      $display("FAIL partial_last: size=%0d keep=%h len=%0d eof=%b err=%b, required 17 3 66 1 0",
               act_q.size(), act_q[16].keep, act_q[16].len, act_q[16].eof, act_q[16].err);
    end
    send_frame(10, 7, -1, 1'b0, 2, le);
    drain();
    compared++;
    if (act_q.size() != 20 || act_q[17].sof !== 1'b1 || act_q[19].keep !== 4'h3 ||
        act_q[19].err !== 1'b1 || act_q[19].len !== 11'd10 || act_q[19].eof !== 1'b1) begin
      mismatched++;
      $display("FAIL runt_last: size=%0d sof=%b keep=%h err=%b len=%0d, required 20 1 3 1 10",
               act_q.size(), act_q[17].sof, act_q[19].keep, act_q[19].err, act_q[19].len);
    end
    compared++;
    if (act_q.size() !== exp_q.size()) begin
      mismatched++;
      $display("FAIL pr_count: got %0d words, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      compared++;
      if (act_q[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL pr_word%0d: got e=%0d d=%h s=%b e=%b er=%b k=%h l=%0d, expected e=%0d d=%h s=%b e=%b er=%b k=%h l=%0d",
                 i, act_q[i].edge_n, act_q[i].data, act_q[i].sof, act_q[i].eof, act_q[i].err, act_q[i].keep, act_q[i].len,
                 exp_q[i].edge_n, exp_q[i].data, exp_q[i].sof, exp_q[i].eof, exp_q[i].err, exp_q[i].keep, exp_q[i].len);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_errors();
    int unsigned le;
    send_frame(100, 7, 19, 1'b0, 2, le);
    drain();
    compared++;
    if (act_q.size() != 25 || act_q[24].err !== 1'b1 || act_q[24].len !== 11'd100 || act_q[24].eof !== 1'b1) begin
      mismatched++;
      $display("FAIL rx_er_eof: size=%0d err=%b len=%0d eof=%b, required 25 1 100 1",
               act_q.size(), act_q[24].err, act_q[24].len, act_q[24].eof);
    end
    act_q.delete();
    exp_q.delete();
    send_frame(1600, 7, -1, 1'b0, 2, le);
    drain();
    compared++;
    if (act_q.size() != 380 || act_q[379].err !== 1'b1 || act_q[379].len !== 11'd1518 ||
        act_q[379].keep !== 4'h3 || act_q[379].edge_n !== le + 2) begin
      mismatched++;
      $display("FAIL oversize_eof: size=%0d err=%b len=%0d keep=%h edge=%0d, required 380 1 1518 3 edge=%0d",
               act_q.size(), act_q[379].err, act_q[379].len, act_q[379].keep, act_q[379].edge_n, le + 2);
    end
    compared++;
    if (act_q.size() !== exp_q.size()) begin
      mismatched++;
      $display("FAIL err_count: got %0d words, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      compared++;
      if (act_q[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL err_word%0d: got e=%0d d=%h s=%b e=%b er=%b k=%h l=%0d, expected e=%0d d=%h s=%b e=%b er=%b k=%h l=%0d",
                 i, act_q[i].edge_n, act_q[i].data, act_q[i].sof, act_q[i].eof, act_q[i].err, act_q[i].keep, act_q[i].len,
                 exp_q[i].edge_n, exp_q[i].data, exp_q[i].sof, exp_q[i].eof, exp_q[i].err, exp_q[i].keep, exp_q[i].len);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int unsigned le;
    int          nsof;
    int          neof;
    send_frame(64, 7, -1, 1'b0, 1, le);
    send_frame(64, 7, -1, 1'b0, 1, le);
    drain();
    nsof = 0;
    neof = 0;
    foreach (act_q[i]) begin
      if (act_q[i].sof === 1'b1) nsof++;
      if (act_q[i].eof === 1'b1 && act_q[i].err === 1'b0) neof++;
    end
    compared++;
    if (act_q.size() != 32 || nsof != 2 || neof != 2) begin
      mismatched++;
      $display("FAIL b2b_shape: words=%0d sof=%0d clean_eof=%0d, required 32 2 2", act_q.size(), nsof, neof);
    end
    compared++;
    if (act_q.size() !== exp_q.size()) begin
      mismatched++;
      $display("FAIL b2b_count: got %0d words, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      compared++;
      if (act_q[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL b2b_word%0d: got e=%0d d=%h s=%b e=%b er=%b k=%h l=%0d, expected e=%0d d=%h s=%b e=%b er=%b k=%h l=%0d",
                 i, act_q[i].edge_n, act_q[i].data, act_q[i].sof, act_q[i].eof, act_q[i].err, act_q[i].keep, act_q[i].len,
                 exp_q[i].edge_n, exp_q[i].data, exp_q[i].sof, exp_q[i].eof, exp_q[i].err, exp_q[i].keep, exp_q[i].len);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_mid_reset();
    int unsigned le;
    int          neof;
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (i == 31 || i == 32) begin
        compared++;
        if ({bus.valid_o, bus.sof_o, bus.eof_o, bus.err_o, bus.keep_o, bus.frame_len_o, bus.data_o} !== '0) begin
          mismatched++;
          $display("FAIL midrst_outputs%0d: valid=%b data=%h eof=%b, required all zero", i, bus.valid_o, bus.data_o, bus.eof_o);
        end
      end
      rxd = 8'($urandom);
      dv  = 1'b1;
      er  = 1'b0;
      rst = (i == 30);
    end
    for (int i = 0; i < 3; i++) drive(8'h00, 1'b0, 1'b0);
    drain();
    neof = 0;
    foreach (act_q[i]) if (act_q[i].eof !== 1'b0) neof++;
    compared++;
    if (act_q.size() != 7 || neof != 0) begin
      mismatched++;
      $display("FAIL midrst_discard: words=%0d eof_words=%0d, required 7 pre-reset words and no eof", act_q.size(), neof);
    end
    act_q.delete();
    send_frame(80, 7, -1, 1'b0, 2, le);
    drain();
    compared++;
    if (act_q.size() !== exp_q.size()) begin
      mismatched++;
      $display("FAIL midrst_count: got %0d words, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      compared++;
      if (act_q[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL midrst_word%0d: got e=%0d d=%h s=%b e=%b er=%b k=%h l=%0d, expected e=%0d d=%h s=%b e=%b er=%b k=%h l=%0d",
                 i, act_q[i].edge_n, act_q[i].data, act_q[i].sof, act_q[i].eof, act_q[i].err, act_q[i].keep, act_q[i].len,
                 exp_q[i].edge_n, exp_q[i].data, exp_q[i].sof, exp_q[i].eof, exp_q[i].err, exp_q[i].keep, exp_q[i].len);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_preamble_and_random();
    int unsigned le;
    int          len;
    int          pre_n;
    int          er_idx;
    send_frame(70, 5, -1, 1'b0, 2, le);
    send_frame(3, 0, -1, 1'b0, 1, le);
    send_frame(0, 7, -1, 1'b0, 1, le);
    for (int f = 0; f < 14; f++) begin
      len    = int'($urandom_range(0, 140));
      pre_n  = ($urandom_range(0, 1) == 0) ? 7 : int'($urandom_range(0, 9));
      er_idx = ($urandom_range(0, 3) == 0 && len > 0) ? int'($urandom_range(0, len - 1)) : -1;
      send_frame(len, pre_n, er_idx, 1'b0, int'($urandom_range(1, 3)), le);
    end
    drain();
    compared++;
    if (act_q.size() !== exp_q.size()) begin
      mismatched++;
      $display("FAIL rand_count: got %0d words, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      compared++;
      if (act_q[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL rand_word%0d: got e=%0d d=%h s=%b e=%b er=%b k=%h l=%0d, expected e=%0d d=%h s=%b e=%b er=%b k=%h l=%0d",
                 i, act_q[i].edge_n, act_q[i].data, act_q[i].sof, act_q[i].eof, act_q[i].err, act_q[i].keep, act_q[i].len,
                 exp_q[i].edge_n, exp_q[i].data, exp_q[i].sof, exp_q[i].eof, exp_q[i].err, exp_q[i].keep, exp_q[i].len);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_min_frame();
    test_partial_and_runt();
    test_errors();
    test_back_to_back();
    test_mid_reset();
    test_preamble_and_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gmii_rx_word_packer.md
Name: gmii_rx_word_packer

Overview:
- Receive-side front end of the 1G parser. Takes the raw GMII byte stream, strips preamble/SFD and packs payload bytes little-endian into DATA_W-bit words.
- Each word is emitted with a frame status bundle. Output feeds data_status_pipeline directly downstream: data_o goes to data_i, and the concatenated status goes to status_i.
- Also reports frame length and framing errors: runt, oversize, rx_er.

Parameters:
- DATA_W, 32, output word width; must be a multiple of 8, with BYTES = DATA_W/8.
- MIN_FRAME_BYTES, 64, payload byte count (post-SFD, FCS included) below which a frame is a runt.
- MAX_FRAME_BYTES, 1518, largest legal payload byte count; LEN_W = $clog2(MAX_FRAME_BYTES+1).

Ports:
- clk  in  1  system clock, 125 MHz GMII domain.
- rst  in  1  synchronous, active-high reset.
- gmii_rxd_i  in  8  GMII receive byte.
- gmii_rx_dv_i  in  1  GMII data valid.
- gmii_rx_er_i  in  1  GMII receive error.
- data_o  out  DATA_W  packed word; byte lane 0 [7:0] holds the earliest byte.
- valid_o  out  1  data_o and all status outputs are valid this cycle.
- sof_o  out  1  first word of a frame.
- eof_o  out  1  last word of a frame.
- err_o  out  1  frame error; meaningful only when eof_o=1.
- keep_o  out  BYTES  per-lane byte valid; all ones except possibly on the eof word.
- frame_len_o  out  LEN_W  payload byte count; meaningful only when eof_o=1.

Behaviour:
- Clocking and reset:
  - One clock; rst is synchronous, active-high.
  - During reset and on the cycle after it: all outputs are 0, and the state is WAIT_IDLE.
- States:
  - WAIT_IDLE: dv=0 -> IDLE.
  - IDLE:
    - dv=1 & rxd=0x55 -> PREAMBLE.
    - dv=1 & rxd=0xD5 -> PAYLOAD.
    - dv=1 & any other byte -> WAIT_IDLE.
  - PREAMBLE:
    - 0x55 -> stay.
    - 0xD5 -> PAYLOAD.
    - any other byte -> WAIT_IDLE.
    - dv=0 -> IDLE, with no output.
  - PAYLOAD: each dv=1 byte goes into the next lane and increments the byte counter. dv=0 ends the frame -> IDLE.
- Word hold rule:
  - A filled word is held internally until the next input cycle decides whether it is last.
  - If the next cycle brings another payload byte, the held word is registered out with eof=0.
  - If the next cycle has dv=0, the held word is registered out with eof=1.
  - valid_o therefore asserts 2 clock edges after the word's final byte is sampled.
- Partial final word: emitted on the edge after dv=0 is sampled, with keep_o = (1<<n)-1 for n filled lanes.
- sof_o is set on the first emitted word of each frame. It may coincide with eof_o when the frame is at most BYTES bytes.
- Zero-byte frame (SFD then dv=0): nothing is emitted.
- Errors:
  - err is sticky per frame and is set by any of:
    - rx_er=1 during PAYLOAD;
    - frame_len < MIN_FRAME_BYTES at eof;
    - oversize.
  - rx_er outside PAYLOAD is ignored.
- Oversize: byte number MAX_FRAME_BYTES+1 is discarded. The held word (full or partial) is emitted next cycle with eof=1, err=1 and frame_len=MAX_FRAME_BYTES. The state then goes to WAIT_IDLE.
- Back-to-back frames: a single dv=0 cycle between frames is sufficient. The eof emission of frame N overlaps IDLE/PREAMBLE of frame N+1, and no bytes are lost.
- Reset mid-frame:
  - The partial frame is discarded with no eof.
  - If dv is still high after reset, the remaining bytes are ignored until dv=0.
- valid_o is never asserted for two words of different frames in the same cycle; at most one word is emitted per cycle.

Optional Feature:
- Macro: GMII_PACKER_PREAMBLE_CHECK_EN.
- When defined:
  - A 3-bit counter requires exactly 7 bytes of 0x55 before 0xD5.
  - Fewer or more -> WAIT_IDLE; the frame is dropped silently.
  - IDLE->PAYLOAD directly on 0xD5 is not allowed.
- When undefined: any count of 0x55 (0..n) before SFD is accepted.

Decomposition:
- Package eth_rx_pkg holds:
  - PREAMBLE_BYTE=8'h55 and SFD_BYTE=8'hD5;
  - the state enum {WAIT_IDLE, IDLE, PREAMBLE, PAYLOAD};
  - the packed struct rx_status_t {sof, eof, err, keep, frame_len}, with its width constant exported for data_status_pipeline STATUS_W.
- Sub-module byte_lane_packer: lane index, shift-in of bytes, and the held-word register with a flush control. The FSM, counters and error logic remain in the top.

Test Plan:
- Minimal frame: 7x0x55, 0xD5, 64 payload bytes 0x00..0x3F, then dv=0.
  - Expect 16 words; word 0 = 0x03020100 with sof=1.
  - Last word 0x3F3E3D3C with eof=1, keep=0xF, err=0, frame_len=64.
  - Last word valid exactly 2 edges after byte 0x3F.
- Partial final word: 66-byte frame.
  - Expect 17 words; final keep=0x3, frame_len=66.
- Runt: 10-byte frame.
  - Expect sof word, then eof word with keep=0x3, err=1, frame_len=10.
- Error and oversize:
  - rx_er pulsed on byte 20 of a 100-byte frame -> eof word err=1, frame_len=100.
  - 1600-byte frame -> eof at byte 1518 with err=1, then no valid_o until the next frame.
- Back-to-back: two 64-byte frames with one dv=0 gap cycle.
  - Expect 32 words, two sof/eof pairs, both err=0.
- Reset: rst asserted at byte 30 and dv held high for 40 more bytes.
  - Expect no valid_o until the next full frame, which is then packed correctly.
  - With GMII_PACKER_PREAMBLE_CHECK_EN, a 5-byte preamble frame produces no output.
